// File: rtl/jpeg_idct_pkg.sv
// Shared defaults and helpers for the IDCT transpose buffer.
package jpeg_idct_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_BLOCK_DIM = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Swap the row and column fields of a raster index (each field hw bits wide).
  function automatic int tr_addr(input int idx, input int hw);
    int mask;
    mask = (1 << hw) - 1;
    return ((idx & mask) << hw) | ((idx >> hw) & mask);
  endfunction

endpackage

// File: rtl/jpeg_idct_tbuf_ram.sv
// Two-bank simple dual-port store: one write port, one synchronous read port.
module jpeg_idct_tbuf_ram #(
  parameter int WIDTH = 16,
  parameter int AW    = 6
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW:0]      waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW:0]      raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int N = 2 << AW;

  logic [WIDTH-1:0] mem_q [N];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/jpeg_idct_transpose_buf.sv
// Ping-pong transpose buffer between IDCT row and column passes; raster in,
// column-major (or raster) out, flow-controlled on both sides.
module jpeg_idct_transpose_buf
  import jpeg_idct_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BLOCK_DIM = DEF_BLOCK_DIM,
  parameter bit TRANSPOSE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_valid_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             wr_ready_o,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_last_o,
  input  logic             rd_ready_i,
  output logic             idle_o
);

  localparam int DEPTH = BLOCK_DIM * BLOCK_DIM;
  localparam int AW    = clog2(DEPTH);
  localparam int HW    = AW / 2;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic             wr_bank_q, wr_bank_d;
  logic [AW-1:0]    wr_idx_q, wr_idx_d;
  logic             rd_bank_q, rd_bank_d;
  logic [AW-1:0]    rd_idx_q, rd_idx_d;
  logic [1:0]       full_q, full_d;
  logic             rd_vld_p1_q, rd_vld_p1_d;
  logic             rd_last_p1_q, rd_last_p1_d;
  logic [1:0]       skid_cnt_q, skid_cnt_d;
  logic             skid_wptr_q, skid_wptr_d;
  logic             skid_rptr_q, skid_rptr_d;
  logic [WIDTH-1:0] skid_data_q [2];
  logic [1:0]       skid_last_q;

  logic             wr_fire, wr_commit;
  logic             rd_issue, rd_release, rd_pop;
  logic [2:0]       occ;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] ram_rdata;

  assign wr_ready_o = ~full_q[wr_bank_q];
  assign wr_fire    = wr_valid_i & wr_ready_o;
  assign wr_commit  = wr_fire & (wr_idx_q == LAST_IDX);

  assign rd_valid_o = (skid_cnt_q != 2'd0);
  assign rd_pop     = rd_valid_o & rd_ready_i;
  // A pop this cycle frees a slot, so issue can keep pace with a streaming consumer.
  assign occ        = {1'b0, skid_cnt_q} + {2'b00, rd_vld_p1_q};
  assign rd_issue   = full_q[rd_bank_q] & (occ < (3'd2 + {2'b00, rd_pop}));
  assign rd_release = rd_issue & (rd_idx_q == LAST_IDX);
  assign rd_addr    = TRANSPOSE ? AW'(tr_addr(int'(rd_idx_q), HW)) : rd_idx_q;

  assign rd_data_o  = rd_valid_o ? skid_data_q[skid_rptr_q] : '0;
  assign rd_last_o  = rd_valid_o & skid_last_q[skid_rptr_q];
  assign idle_o     = (full_q == 2'b00) & (wr_idx_q == '0) & ~rd_valid_o & ~rd_vld_p1_q;

  always_comb begin
    wr_bank_d    = wr_bank_q;
    wr_idx_d     = wr_idx_q;
    rd_bank_d    = rd_bank_q;
    rd_idx_d     = rd_idx_q;
    full_d       = full_q;
    rd_vld_p1_d  = rd_issue;
    rd_last_p1_d = rd_release;
    skid_cnt_d   = skid_cnt_q + {1'b0, rd_vld_p1_q} - {1'b0, rd_pop};
    skid_wptr_d  = skid_wptr_q ^ rd_vld_p1_q;
    skid_rptr_d  = skid_rptr_q ^ rd_pop;
    if (wr_fire) begin
      wr_idx_d = wr_idx_q + AW'(1);
      if (wr_commit) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    // Commit and release always target different banks, so both may land together.
    if (rd_issue) begin
      rd_idx_d = rd_idx_q + AW'(1);
      if (rd_release) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_bank_q    <= 1'b0;
      wr_idx_q     <= '0;
      rd_bank_q    <= 1'b0;
      rd_idx_q     <= '0;
      full_q       <= 2'b00;
      rd_vld_p1_q  <= 1'b0;
      rd_last_p1_q <= 1'b0;
      skid_cnt_q   <= 2'd0;
      skid_wptr_q  <= 1'b0;
      skid_rptr_q  <= 1'b0;
    end else begin
      wr_bank_q    <= wr_bank_d;
      wr_idx_q     <= wr_idx_d;
      rd_bank_q    <= rd_bank_d;
      rd_idx_q     <= rd_idx_d;
      full_q       <= full_d;
      rd_vld_p1_q  <= rd_vld_p1_d;
      rd_last_p1_q <= rd_last_p1_d;
      skid_cnt_q   <= skid_cnt_d;
      skid_wptr_q  <= skid_wptr_d;
      skid_rptr_q  <= skid_rptr_d;
    end
  end

  // Stage p1 -> skid: RAM output captured the cycle after issue.
  always_ff @(posedge clk_i) begin
    if (rd_vld_p1_q) begin
      skid_data_q[skid_wptr_q] <= ram_rdata;
      skid_last_q[skid_wptr_q] <= rd_last_p1_q;
    end
  end

  jpeg_idct_tbuf_ram #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_fire),
    .waddr_i ({wr_bank_q, wr_idx_q}),
    .wdata_i (wr_data_i),
    .re_i    (rd_issue),
    .raddr_i ({rd_bank_q, rd_addr}),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_jpeg_idct_transpose_buf.sv
// Directed bench for the transpose buffer: 8x8 transposing instance plus a 4x4 raster instance.
module tb_jpeg_idct_transpose_buf;

  logic        clk;
  logic        rst_i;
  logic        wr_valid_i;
  logic [15:0] wr_data_i;
  logic        wr_ready_o;
  logic        rd_valid_o;
  logic [15:0] rd_data_o;
  logic        rd_last_o;
  logic        rd_ready_i;
  logic        idle_o;

  logic        w4_valid;
  logic [11:0] w4_data;
  logic        w4_ready;
  logic        r4_valid;
  logic [11:0] r4_data;
  logic        r4_last;
  logic        r4_ready;
  logic        idle4;

  int          n_cmp = 0;
  int          n_err = 0;
  int          wcnt = 0;
  int          rcnt = 0;
  int          gap_lo = 0;
  int          gap_hi = 0;
  int          gap_cnt = 0;
  int          stall_cnt = 0;
  bit          mon_en = 0;
  bit          hold = 0;
  logic [15:0] hold_data;
  logic        hold_last;
  int          n;
  int          k4;
  int          wi4;
  int          base;

  jpeg_idct_transpose_buf dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .wr_valid_i (wr_valid_i),
    .wr_data_i  (wr_data_i),
    .wr_ready_o (wr_ready_o),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .rd_last_o  (rd_last_o),
    .rd_ready_i (rd_ready_i),
    .idle_o     (idle_o)
  );

  jpeg_idct_transpose_buf #(.WIDTH(12), .BLOCK_DIM(4), .TRANSPOSE(1'b0)) dut4 (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .wr_valid_i (w4_valid),
    .wr_data_i  (w4_data),
    .wr_ready_o (w4_ready),
    .rd_valid_o (r4_valid),
    .rd_data_o  (r4_data),
    .rd_last_o  (r4_last),
    .rd_ready_i (r4_ready),
    .idle_o     (idle4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sequence number n was written as value n; output k of a block is element (k%8, k/8).
  function automatic int exp_at(input int k);
    int b, j;
    b = k / 64;
    j = k % 64;
    return b * 64 + (j % 8) * 8 + j / 8;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (hold) begin
        chk("hold_vld", 32'(rd_valid_o), 32'd1);
        chk("hold_data", 32'(rd_data_o), 32'(hold_data));
        chk("hold_last", 32'(rd_last_o), 32'(hold_last));
      end
      if (wr_valid_i && !wr_ready_o) stall_cnt++;
      if (!rd_valid_o && rcnt > gap_lo && rcnt < gap_hi) gap_cnt++;
      if (wr_valid_i && wr_ready_o) wcnt++;
      if (rd_valid_o && rd_ready_i) begin
        chk("rd_data", 32'(rd_data_o), 32'(exp_at(rcnt)));
        chk("rd_last", 32'(rd_last_o), (rcnt % 64 == 63) ? 32'd1 : 32'd0);
        rcnt++;
      end
      hold      = rd_valid_o && !rd_ready_i;
      hold_data = rd_data_o;
      hold_last = rd_last_o;
    end else begin
      hold = 1'b0;
    end
  end

  task automatic cyc(input bit wv, input bit rr);
    wr_valid_i = wv;
    wr_data_i  = 16'(wcnt);
    rd_ready_i = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int b);
    mon_en     = 1'b0;
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    w4_valid   = 1'b0;
    r4_ready   = 1'b0;
    rst_i      = 1'b1;
    @(posedge clk);
    #1;
    rst_i  = 1'b0;
    wcnt   = b;
    rcnt   = b;
    mon_en = 1'b1;
  endtask

  task automatic run(input string tag, input int tw, input int tr, input int pw, input int pr,
                     input int bound);
    int c;
    c = 0;
    while ((wcnt < tw || rcnt < tr) && c < bound) begin
      cyc((wcnt < tw) && ($urandom_range(99) < pw), $urandom_range(99) < pr);
      c++;
    end
    chk({tag, "_wcnt"}, 32'(wcnt), 32'(tw));
    chk({tag, "_rcnt"}, 32'(rcnt), 32'(tr));
  endtask

  initial begin
    rst_i = 1'b1; wr_valid_i = 1'b0; wr_data_i = '0; rd_ready_i = 1'b0;
    w4_valid = 1'b0; w4_data = '0; r4_ready = 1'b0;

    // Reset state and single transposed block with first-output latency.
    do_reset(0);
    #3;
    chk("rst_wr_ready", 32'(wr_ready_o), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_rd_data", 32'(rd_data_o), 32'd0);
    chk("rst_rd_last", 32'(rd_last_o), 32'd0);
    chk("rst_idle", 32'(idle_o), 32'd1);
    for (int i = 0; i < 64; i++) cyc(1'b1, 1'b1);
    chk("t1_wcnt64", 32'(wcnt), 32'd64);
    #3 chk("t1_lat0", 32'(rd_valid_o), 32'd0);
    chk("t1_busy", 32'(idle_o), 32'd0);
    cyc(1'b0, 1'b1);
    #3 chk("t1_lat1", 32'(rd_valid_o), 32'd0);
    cyc(1'b0, 1'b1);
    #3 chk("t1_lat2", 32'(rd_valid_o), 32'd1);
    chk("t1_first", 32'(rd_data_o), 32'd0);
    run("t1", 64, 64, 0, 100, 200);
    #3 chk("t1_idle", 32'(idle_o), 32'd1);

    // Four back-to-back blocks, both sides always ready.
    base = 256;
    do_reset(base);
    gap_lo = base; gap_hi = base + 256; gap_cnt = 0; stall_cnt = 0;
    run("t2", base + 256, base + 256, 100, 100, 400);
    chk("t2_gaps", 32'(gap_cnt), 32'd0);
    chk("t2_wr_stalls", 32'(stall_cnt), 32'd0);
    gap_hi = 0;

    // Reader stalled: both banks fill, writer blocked, then release.
    base = 512;
    do_reset(base);
    for (int i = 0; i < 140; i++) cyc(1'b1, 1'b0);
    #3;
    chk("t3_wcnt", 32'(wcnt), 32'(base + 128));
    chk("t3_wr_ready", 32'(wr_ready_o), 32'd0);
    chk("t3_rd_valid", 32'(rd_valid_o), 32'd1);
    chk("t3_rcnt", 32'(rcnt), 32'(base));
    @(posedge clk);
    #1;
    n = 0;
    wr_valid_i = 1'b1; wr_data_i = 16'(wcnt); rd_ready_i = 1'b1;
    while (n < 200) begin
      #3;
      if (wr_ready_o) break;
      @(posedge clk);
      #1;
      n++;
    end
    wr_valid_i = 1'b0;
    chk("t3_release_cycles", 32'(n), 32'd62);
    @(posedge clk);
    #1;
    run("t3d", base + 128, base + 128, 0, 100, 300);

    // Random valid/ready over 20 blocks.
    base = 768;
    do_reset(base);
    run("t4", base + 1280, base + 1280, 50, 50, 12000);
    #3 chk("t4_idle", 32'(idle_o), 32'd1);

    // Reset in the middle of traffic, then a clean block.
    base = 2048;
    do_reset(base);
    run("t5a", base + 94, base, 100, 0, 200);
    run("t5b", base + 94, base + 10, 0, 100, 50);
    do_reset(2560);
    #3;
    chk("t5_rst_idle", 32'(idle_o), 32'd1);
    chk("t5_rst_valid", 32'(rd_valid_o), 32'd0);
    chk("t5_rst_ready", 32'(wr_ready_o), 32'd1);
    run("t5c", 2560 + 64, 2560 + 64, 100, 100, 300);
    #3 chk("t5_idle", 32'(idle_o), 32'd1);

    // 4x4 raster instance, two blocks.
    do_reset(0);
    mon_en = 1'b0;
    k4 = 0;
    wi4 = 0;
    for (int c = 0; c < 120 && k4 < 32; c++) begin
      w4_valid = (wi4 < 32);
      w4_data  = 12'(12'hA00 + wi4);
      r4_ready = 1'b1;
      #3;
      if (r4_valid) begin
        chk("t6_data", 32'(r4_data), 32'(12'hA00 + k4));
        chk("t6_last", 32'(r4_last), (k4 % 16 == 15) ? 32'd1 : 32'd0);
        k4++;
      end
      if (w4_valid && w4_ready) wi4++;
      @(posedge clk);
      #1;
    end
    w4_valid = 1'b0;
    chk("t6_count", 32'(k4), 32'd32);
    #3 chk("t6_idle", 32'(idle4), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
